wb_stage: RTL and testbench

WB_STAGE -- requirements
Module: wb_stage

---
 rtl/wb_stage.sv | 102 ++++++++++
 tb/tb_wb_stage.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_stage.sv
// Write-back stage: MEM_WB pipeline register, register-bank write port, HLT tracking and retire count.
// Latency: inputs sampled at edge n drive RegWrite/rd/wr_data after edge n; the bank commits at edge n+1.
// Backpressure: none; one instruction per cycle, and instructions arriving behind a retiring HLT are dropped.
module wb_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_valid,
  input  logic        mem_regwrite,
  input  logic        mem_memtoreg,
  input  logic        mem_regdst,
  input  logic        mem_halt,
  input  logic [4:0]  mem_rd0,
  input  logic [4:0]  mem_rd1,
  input  logic [31:0] mem_alu_out,
  input  logic [31:0] mem_lmd,
  output logic        RegWrite,
  output logic [4:0]  rd,
  output logic [31:0] wr_data,
  output logic        halted,
  output logic [15:0] retire_cnt
);

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } state_t;

  typedef struct packed {
    logic        valid;
    logic        regwrite;
    logic        memtoreg;
    logic        halt;
    logic [4:0]  dest;
    logic [31:0] alu_out;
    logic [31:0] lmd;
  } mem_wb_t;

  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  state_t      state;
  state_t      state_nxt;
  mem_wb_t     mem_wb;
  mem_wb_t     mem_wb_nxt;
  logic [15:0] retire_cnt_q;
  logic        hlt_in_wb;
  logic        retire_en;

  // An HLT sitting in MEM_WB retires this cycle; everything behind it is squashed.
  assign hlt_in_wb = mem_wb.valid & mem_wb.halt;
  assign retire_en = mem_wb.valid & (state == RUN);

  // Next-state: RUN moves to HALTED when HLT retires; only reset leaves HALTED.
  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (hlt_in_wb) state_nxt = HALTED;
      HALTED:  state_nxt = HALTED;
      default: state_nxt = RUN;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= RUN;
    else       state <= state_nxt;
  end

  // Next MEM_WB contents: capture MEM fields, resolve destination, squash valid behind HLT or when halted.
  always_comb begin
    mem_wb_nxt          = '0;
    mem_wb_nxt.regwrite = mem_regwrite;
    mem_wb_nxt.memtoreg = mem_memtoreg;
    mem_wb_nxt.halt     = mem_halt;
    mem_wb_nxt.dest     = mem_regdst ? mem_rd1 : mem_rd0;
    mem_wb_nxt.alu_out  = mem_alu_out;
    mem_wb_nxt.lmd      = mem_lmd;
    mem_wb_nxt.valid    = mem_valid & (state == RUN) & ~hlt_in_wb;
  end

  // MEM_WB pipeline register; reset clears every field so outputs are never X.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) mem_wb <= '0;
    else       mem_wb <= mem_wb_nxt;
  end

  // Retire counter: every valid instruction retired while running, saturating at all-ones.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                   retire_cnt_q <= '0;
    else if (retire_en && retire_cnt_q != CNT_MAX) retire_cnt_q <= retire_cnt_q + 16'd1;
  end

  // Register-bank write port and status, purely from MEM_WB and state; R0 writes are dropped.
  always_comb begin
    RegWrite   = mem_wb.valid & mem_wb.regwrite & ~mem_wb.halt &
                 (mem_wb.dest != 5'd0) & (state == RUN);
    rd         = mem_wb.dest;
    wr_data    = mem_wb.memtoreg ? mem_wb.lmd : mem_wb.alu_out;
    halted     = (state == HALTED);
    retire_cnt = retire_cnt_q;
  end

endmodule

// File: tb/tb_wb_stage.sv
module tb_wb_stage;

  logic        clk;
  logic        reset;
  logic        mem_valid;
  logic        mem_regwrite;
  logic        mem_memtoreg;
  logic        mem_regdst;
  logic        mem_halt;
  logic [4:0]  mem_rd0;
  logic [4:0]  mem_rd1;
  logic [31:0] mem_alu_out;
  logic [31:0] mem_lmd;
  logic        RegWrite;
  logic [4:0]  rd;
  logic [31:0] wr_data;
  logic        halted;
  logic [15:0] retire_cnt;

  int pass_cnt;
  int total_cnt;
  logic [15:0] exp_cnt;

  wb_stage dut (
    .clk          (clk),
    .reset        (reset),
    .mem_valid    (mem_valid),
    .mem_regwrite (mem_regwrite),
    .mem_memtoreg (mem_memtoreg),
    .mem_regdst   (mem_regdst),
    .mem_halt     (mem_halt),
    .mem_rd0      (mem_rd0),
    .mem_rd1      (mem_rd1),
    .mem_alu_out  (mem_alu_out),
    .mem_lmd      (mem_lmd),
    .RegWrite     (RegWrite),
    .rd           (rd),
    .wr_data      (wr_data),
    .halted       (halted),
    .retire_cnt   (retire_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic drive(input logic v, input logic rw, input logic m2r, input logic rdst,
                       input logic h, input logic [4:0] r0, input logic [4:0] r1,
                       input logic [31:0] alu, input logic [31:0] lmd);
    mem_valid    = v;
    mem_regwrite = rw;
    mem_memtoreg = m2r;
    mem_regdst   = rdst;
    mem_halt     = h;
    mem_rd0      = r0;
    mem_rd1      = r1;
    mem_alu_out  = alu;
    mem_lmd      = lmd;
  endtask

  task automatic bubble();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 32'h0, 32'h0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 5'd3, 5'd4, 32'h1111, 32'h2222);
    #1;
    total_cnt++; if (RegWrite !== 1'b0) $display("FAIL reset_regwrite got=%b exp=0", RegWrite); else pass_cnt++;
    total_cnt++; if (rd !== 5'd0) $display("FAIL reset_rd got=%0d exp=0", rd); else pass_cnt++;
    total_cnt++; if (wr_data !== 32'h0) $display("FAIL reset_wr_data got=%h exp=0", wr_data); else pass_cnt++;
    total_cnt++; if (halted !== 1'b0) $display("FAIL reset_halted got=%b exp=0", halted); else pass_cnt++;
    total_cnt++; if (retire_cnt !== 16'd0) $display("FAIL reset_cnt got=%0d exp=0", retire_cnt); else pass_cnt++;
    step(); step();
    total_cnt++; if (RegWrite !== 1'b0) $display("FAIL reset_held_regwrite got=%b exp=0", RegWrite); else pass_cnt++;
    bubble();
    reset = 1'b0;
    exp_cnt = 16'd0;
  endtask

  task automatic test_alu_write();
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 5'd9, 5'd5, 32'h0000_00AB, 32'h5555_5555);
    step();
    bubble();
    total_cnt++; if (RegWrite !== 1'b1) $display("FAIL alu_regwrite got=%b exp=1", RegWrite); else pass_cnt++;
    total_cnt++; if (rd !== 5'd5) $display("FAIL alu_rd got=%0d exp=5", rd); else pass_cnt++;
    total_cnt++; if (wr_data !== 32'h0000_00AB) $display("FAIL alu_wr_data got=%h exp=000000ab", wr_data); else pass_cnt++;
    total_cnt++; if (retire_cnt !== exp_cnt) $display("FAIL alu_cnt_before got=%0d exp=%0d", retire_cnt, exp_cnt); else pass_cnt++;
    step();
    exp_cnt++;
    total_cnt++; if (retire_cnt !== exp_cnt) $display("FAIL alu_cnt_after got=%0d exp=%0d", retire_cnt, exp_cnt); else pass_cnt++;
    total_cnt++; if (RegWrite !== 1'b0) $display("FAIL alu_bubble_regwrite got=%b exp=0", RegWrite); else pass_cnt++;
  endtask

  task automatic test_load_write();
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd7, 5'd9, 32'h0000_1234, 32'hDEAD_BEEF);
    step();
    bubble();
    total_cnt++; if (RegWrite !== 1'b1) $display("FAIL load_regwrite got=%b exp=1", RegWrite); else pass_cnt++;
    total_cnt++; if (rd !== 5'd7) $display("FAIL load_rd got=%0d exp=7", rd); else pass_cnt++;
    total_cnt++; if (wr_data !== 32'hDEAD_BEEF) $display("FAIL load_wr_data got=%h exp=deadbeef", wr_data); else pass_cnt++;
    step();
    exp_cnt++;
    total_cnt++; if (retire_cnt !== exp_cnt) $display("FAIL load_cnt got=%0d exp=%0d", retire_cnt, exp_cnt); else pass_cnt++;
  endtask

  task automatic test_r0_and_nowrite();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd6, 32'h0000_0055, 32'h0);
    step();
    total_cnt++; if (RegWrite !== 1'b0) $display("FAIL r0_regwrite got=%b exp=0", RegWrite); else pass_cnt++;
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 5'd6, 32'h0000_0066, 32'h0);
    step();
    exp_cnt++;
    bubble();
    total_cnt++; if (RegWrite !== 1'b0) $display("FAIL nowrite_regwrite got=%b exp=0", RegWrite); else pass_cnt++;
    total_cnt++; if (retire_cnt !== exp_cnt) $display("FAIL r0_cnt got=%0d exp=%0d", retire_cnt, exp_cnt); else pass_cnt++;
    step();
    exp_cnt++;
    total_cnt++; if (retire_cnt !== exp_cnt) $display("FAIL nowrite_cnt got=%0d exp=%0d", retire_cnt, exp_cnt); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 5'd3, 32'h0000_0011, 32'h0);
    step();
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd4, 5'd0, 32'h0, 32'h0000_0022);
    total_cnt++; if (rd !== 5'd3 || wr_data !== 32'h11 || RegWrite !== 1'b1)
      $display("FAIL b2b_first got=%b/%0d/%h exp=1/3/00000011", RegWrite, rd, wr_data); else pass_cnt++;
    step();
    exp_cnt++;
    bubble();
    total_cnt++; if (rd !== 5'd4 || wr_data !== 32'h22 || RegWrite !== 1'b1)
      $display("FAIL b2b_second got=%b/%0d/%h exp=1/4/00000022", RegWrite, rd, wr_data); else pass_cnt++;
    step();
    exp_cnt++;
    total_cnt++; if (retire_cnt !== exp_cnt) $display("FAIL b2b_cnt got=%0d exp=%0d", retire_cnt, exp_cnt); else pass_cnt++;
  endtask

  task automatic test_halt();
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 5'd0, 5'd8, 32'h0000_0099, 32'h0);
    step();
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 5'd10, 32'h0000_00A1, 32'h0);
    total_cnt++; if (RegWrite !== 1'b0) $display("FAIL hlt_regwrite got=%b exp=0", RegWrite); else pass_cnt++;
    total_cnt++; if (halted !== 1'b0) $display("FAIL hlt_halted_early got=%b exp=0", halted); else pass_cnt++;
    step();
    exp_cnt++;
    total_cnt++; if (halted !== 1'b1) $display("FAIL hlt_halted got=%b exp=1", halted); else pass_cnt++;
    total_cnt++; if (RegWrite !== 1'b0) $display("FAIL hlt_drop1 got=%b exp=0", RegWrite); else pass_cnt++;
    total_cnt++; if (retire_cnt !== exp_cnt) $display("FAIL hlt_cnt got=%0d exp=%0d", retire_cnt, exp_cnt); else pass_cnt++;
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 5'd11, 32'h0000_00A2, 32'h0);
    step();
    total_cnt++; if (RegWrite !== 1'b0) $display("FAIL hlt_drop2 got=%b exp=0", RegWrite); else pass_cnt++;
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 5'd12, 32'h0000_00A3, 32'h0);
    step();
    bubble();
    total_cnt++; if (RegWrite !== 1'b0) $display("FAIL hlt_drop3 got=%b exp=0", RegWrite); else pass_cnt++;
    step(); step();
    total_cnt++; if (retire_cnt !== exp_cnt) $display("FAIL hlt_cnt_frozen got=%0d exp=%0d", retire_cnt, exp_cnt); else pass_cnt++;
    total_cnt++; if (halted !== 1'b1) $display("FAIL hlt_sticky got=%b exp=1", halted); else pass_cnt++;
  endtask

  task automatic test_async_reset();
    reset = 1'b1;
    #2;
    reset = 1'b0;
    exp_cnt = 16'd0;
    total_cnt++; if (halted !== 1'b0) $display("FAIL rst_clears_halt got=%b exp=0", halted); else pass_cnt++;
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 5'd12, 32'h0000_0077, 32'h0);
    step();
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 5'd13, 32'h0000_0088, 32'h0);
    step();
    bubble();
    total_cnt++; if (RegWrite !== 1'b1 || retire_cnt !== 16'd1)
      $display("FAIL rst_pre got=%b/%0d exp=1/1", RegWrite, retire_cnt); else pass_cnt++;
    #1;
    reset = 1'b1;
    #1;
    total_cnt++; if (RegWrite !== 1'b0) $display("FAIL rst_async_regwrite got=%b exp=0", RegWrite); else pass_cnt++;
    total_cnt++; if (retire_cnt !== 16'd0) $display("FAIL rst_async_cnt got=%0d exp=0", retire_cnt); else pass_cnt++;
    total_cnt++; if (rd !== 5'd0 || wr_data !== 32'h0 || halted !== 1'b0)
      $display("FAIL rst_async_fields got=%0d/%h/%b exp=0/0/0", rd, wr_data, halted); else pass_cnt++;
    @(negedge clk);
    reset = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd14, 5'd0, 32'h0000_00CC, 32'h0);
    step();
    bubble();
    total_cnt++; if (RegWrite !== 1'b1 || rd !== 5'd14 || wr_data !== 32'hCC)
      $display("FAIL rst_first_after got=%b/%0d/%h exp=1/14/000000cc", RegWrite, rd, wr_data); else pass_cnt++;
    step();
    total_cnt++; if (retire_cnt !== 16'd1) $display("FAIL rst_first_cnt got=%0d exp=1", retire_cnt); else pass_cnt++;
  endtask

  task automatic test_saturation();
    reset = 1'b1;
    #2;
    reset = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd1, 5'd2, 32'h0, 32'h0);
    repeat (65535) @(posedge clk);
    #1;
    total_cnt++; if (retire_cnt !== 16'hFFFE) $display("FAIL sat_pre got=%h exp=fffe", retire_cnt); else pass_cnt++;
    step();
    bubble();
    total_cnt++; if (retire_cnt !== 16'hFFFF) $display("FAIL sat_reach got=%h exp=ffff", retire_cnt); else pass_cnt++;
    step();
    total_cnt++; if (retire_cnt !== 16'hFFFF) $display("FAIL sat_hold got=%h exp=ffff", retire_cnt); else pass_cnt++;
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 5'd3, 32'h0000_0001, 32'h0);
    step();
    bubble();
    step();
    total_cnt++; if (retire_cnt !== 16'hFFFF) $display("FAIL sat_extra got=%h exp=ffff", retire_cnt); else pass_cnt++;
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    exp_cnt   = 16'd0;
    reset     = 1'b1;
    bubble();
    test_reset();
    test_alu_write();
    test_load_write();
    test_r0_and_nowrite();
    test_back_to_back();
    test_halt();
    test_async_reset();
    test_saturation();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
